rgb_pwm_driver: RTL and testbench

- Downstream stage of the lighting path: consumes the 24-bit RGB word produced by the colour sequencer/white-select mux (`lightsOut`) and drives three physical LED PWM pins.
- Applies a global brightness factor, with a sleep-driven fade-down/fade-up state machine.
- Colour and brightness updates are applied only at PWM period boundaries, so the LEDs never glitch mid-period.

---
 rtl/lights_pkg.sv | 12 +
 rtl/pwm_channel.sv | 24 ++
 rtl/rgb_pwm_driver.sv | 81 ++++++++
 tb/tb_rgb_pwm_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// lights_pkg: shared widths, RGB channel slices and the fade FSM state type for the LED PWM path
package lights_pkg;
   localparam int PWM_W = 8;
   localparam int RGB_W = 24;
   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;
   typedef enum logic [2:0] {OFF, RUN, FADE_DOWN, DARK, FADE_UP} pwm_state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: scales one colour level by global brightness and drives a registered PWM compare
module pwm_channel
   import lights_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             act,
   input  logic [PWM_W-1:0] level,
   input  logic [PWM_W-1:0] bri,
   input  logic [PWM_W-1:0] cnt,
   output logic             pwm
);
   logic [2*PWM_W-1:0] prod;
   logic [PWM_W-1:0]   duty;
   logic               pwm_d, pwm_q;
   // brightness+1 lets full brightness pass the level through unchanged
   always_comb begin
      prod  = {{PWM_W{1'b0}}, level} * ({{PWM_W{1'b0}}, bri} + (2*PWM_W)'(1));
      duty  = PWM_W'(prod >> PWM_W);
      pwm_d = act && (cnt < duty);
   end
   always_ff @(posedge clk) pwm_q <= rst ? 1'b0 : pwm_d;
   assign pwm = pwm_q;
endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel LED PWM with period-aligned colour latch and sleep-driven brightness fade
module rgb_pwm_driver
   import lights_pkg::*;
#(
   parameter int PRESCALE  = 4,
   parameter int FADE_STEP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sleep,
   input  logic [RGB_W-1:0] colour_in,
   output logic             pwm_r,
   output logic             pwm_g,
   output logic             pwm_b,
   output logic             period_start,
   output logic [PWM_W-1:0] brightness,
   output logic             faded_out
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   pwm_state_t       state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [PWM_W-1:0] cnt_q, cnt_d, bri_q, bri_d;
   logic [RGB_W-1:0] col_q, col_d;
   logic             ps_q, ps_d, run, act, tick, bnd;
   logic [PWM_W:0]   dn, up;
   // dn/up carry one extra bit so under/overflow shows up in the MSB for clamping
   always_comb begin
      run   = state_q != OFF;
      act   = en && run;
      tick  = pre_q == PW'(PRESCALE - 1);
      bnd   = act && tick && cnt_q == '1;
      dn    = {1'b0, bri_q} - (PWM_W+1)'(FADE_STEP);
      up    = {1'b0, bri_q} + (PWM_W+1)'(FADE_STEP);
      pre_d = (!act || tick) ? '0 : pre_q + 1'b1;
      cnt_d = act ? cnt_q + PWM_W'(tick) : '0;
      ps_d  = en && (!run || bnd);
      col_d = ps_d ? colour_in : col_q;
      bri_d = (en && !run) ? '1 :
              !bnd ? bri_q :
              (state_q == FADE_DOWN && sleep) ? (dn[PWM_W] ? '0 : dn[PWM_W-1:0]) :
              (state_q == FADE_UP && !sleep) ? (up[PWM_W] ? '1 : up[PWM_W-1:0]) : bri_q;
   end
   always_comb begin
      state_d = state_q;
      if (!en)
         state_d = OFF;
      else if (!run)
         state_d = RUN;
      else if (bnd)
         case (state_q)
            RUN:       state_d = sleep ? FADE_DOWN : RUN;
            FADE_DOWN: state_d = !sleep ? FADE_UP : (dn[PWM_W] || dn[PWM_W-1:0] == '0) ? DARK : FADE_DOWN;
            DARK:      state_d = sleep ? DARK : FADE_UP;
            FADE_UP:   state_d = sleep ? FADE_DOWN : (up[PWM_W] || up[PWM_W-1:0] == '1) ? RUN : FADE_UP;
            default:   state_d = OFF;
         endcase
   end
   always_comb faded_out = state_q == DARK;
   always_ff @(posedge clk) state_q <= rst ? OFF : state_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
         bri_q <= '1;
         col_q <= '0;
         ps_q  <= 1'b0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         bri_q <= bri_d;
         col_q <= col_d;
         ps_q  <= ps_d;
      end
   end
   assign period_start = ps_q;
   assign brightness   = bri_q;
   pwm_channel u_r (.clk(clk), .rst(rst), .act(act), .level(col_q[R_HI:R_LO]), .bri(bri_q), .cnt(cnt_q), .pwm(pwm_r));
   pwm_channel u_g (.clk(clk), .rst(rst), .act(act), .level(col_q[G_HI:G_LO]), .bri(bri_q), .cnt(cnt_q), .pwm(pwm_g));
   pwm_channel u_b (.clk(clk), .rst(rst), .act(act), .level(col_q[B_HI:B_LO]), .bri(bri_q), .cnt(cnt_q), .pwm(pwm_b));
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: cycle scoreboard against a behavioural model plus table-driven period and fade checks
module tb_rgb_pwm_driver;
   localparam int FS = 64;
   typedef struct { logic [23:0] col; int r; int g; int b; } vec_t;
   typedef struct { bit slp; int bri; int fd; int r; } fade_t;
   logic        clk = 0, rst = 1, en = 0, sleep = 0;
   logic [23:0] colour_in = '0;
   logic        pwm_r, pwm_g, pwm_b, period_start, faded_out;
   logic [7:0]  brightness;
   int          checks = 0, failures = 0;
   logic [12:0] sb[$];
   int          m_st, m_cnt, m_bri;
   logic [23:0] m_col;
   logic [2:0]  m_pwm;
   logic        m_ps;

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(FS)) dut (
      .clk(clk), .rst(rst), .en(en), .sleep(sleep), .colour_in(colour_in),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .period_start(period_start),
      .brightness(brightness), .faded_out(faded_out));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model states: 0 OFF, 1 RUN, 2 FADE_DOWN, 3 DARK, 4 FADE_UP
   task automatic ref_step();
      int ch;
      if (rst) begin
         m_st = 0; m_cnt = 0; m_bri = 255; m_col = '0; m_pwm = '0; m_ps = 0;
      end else if (!en) begin
         m_st = 0; m_cnt = 0; m_pwm = '0; m_ps = 0;
      end else if (m_st == 0) begin
         m_st = 1; m_col = colour_in; m_bri = 255; m_ps = 1; m_pwm = '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            ch = int'((m_col >> (8 * i)) & 24'hFF);
            m_pwm[i] = m_cnt < (ch * (m_bri + 1)) / 256;
         end
         m_ps = m_cnt == 255;
         if (m_cnt == 255) begin
            m_col = colour_in;
            case (m_st)
               1: if (sleep) m_st = 2;
               2: if (!sleep) m_st = 4;
                  else begin
                     m_bri = (m_bri > FS) ? m_bri - FS : 0;
                     if (m_bri == 0) m_st = 3;
                  end
               3: if (!sleep) m_st = 4;
               4: if (sleep) m_st = 2;
                  else begin
                     m_bri = (m_bri + FS > 255) ? 255 : m_bri + FS;
                     if (m_bri == 255) m_st = 1;
                  end
               default: m_st = 0;
            endcase
         end
         m_cnt = (m_cnt + 1) % 256;
      end
   endtask

   task automatic step();
      ref_step();
      sb.push_back({m_pwm, m_ps, 1'(m_st == 3), 8'(m_bri)});
      @(posedge clk); #1;
      chk("cycle", {pwm_r, pwm_g, pwm_b, period_start, faded_out, brightness}, sb.pop_front());
   endtask

   // entered on a period_start sample, returns on the next one
   task automatic run_period(input int chg_at, input logic [23:0] chg, output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      for (int k = 1; k <= 256; k++) begin
         if (k == chg_at) colour_in = chg;
         step();
         r += int'(pwm_r); g += int'(pwm_g); b += int'(pwm_b);
      end
      chk("period_end", period_start, 1);
   endtask

   initial begin
      vec_t  tbl[4];
      fade_t fd[17];
      int    r, g, b, gap, prev_r;
      tbl[0] = '{24'hFF0080, 255, 0, 128};
      tbl[1] = '{24'h00FF00, 0, 255, 0};
      tbl[2] = '{24'h010203, 1, 2, 3};
      tbl[3] = '{24'h7F8001, 127, 128, 1};
      fd[0]  = '{1, 255, 0, 255};
      fd[1]  = '{1, 191, 0, 191};
      fd[2]  = '{1, 127, 0, 127};
      fd[3]  = '{1, 63, 0, 63};
      fd[4]  = '{1, 0, 1, 0};
      fd[5]  = '{0, 0, 0, 0};
      fd[6]  = '{0, 64, 0, 64};
      fd[7]  = '{0, 128, 0, 128};
      fd[8]  = '{0, 192, 0, 192};
      fd[9]  = '{0, 255, 0, 255};
      fd[10] = '{1, 255, 0, 255};
      fd[11] = '{1, 191, 0, 191};
      fd[12] = '{1, 127, 0, 127};
      fd[13] = '{0, 127, 0, 127};
      fd[14] = '{0, 191, 0, 191};
      fd[15] = '{0, 255, 0, 255};
      fd[16] = '{0, 255, 0, 255};
      step(); step();
      chk("rst_bri", brightness, 255);
      chk("rst_outs", {pwm_r, pwm_g, pwm_b, period_start, faded_out}, 0);
      rst = 0;
      step(); step();
      chk("off_outs", {pwm_r, pwm_g, pwm_b, period_start}, 0);
      colour_in = 24'hFF0080; en = 1;
      step();
      chk("en_ps", period_start, 1);
      gap = 0;
      do begin step(); gap++; end while (!period_start && gap < 600);
      chk("ps_gap", gap, 256);
      foreach (tbl[i]) begin
         colour_in = tbl[i].col;
         run_period(0, '0, r, g, b);
         run_period(0, '0, r, g, b);
         chk("tbl_r", r, tbl[i].r);
         chk("tbl_g", g, tbl[i].g);
         chk("tbl_b", b, tbl[i].b);
      end
      colour_in = 24'hFF0080;
      run_period(0, '0, r, g, b);
      run_period(101, 24'h00FF00, r, g, b);
      chk("mid_r", r, 255); chk("mid_g", g, 0); chk("mid_b", b, 128);
      run_period(0, '0, r, g, b);
      chk("new_r", r, 0); chk("new_g", g, 255); chk("new_b", b, 0);
      colour_in = 24'hFF0000;
      run_period(0, '0, r, g, b);
      prev_r = 255;
      foreach (fd[i]) begin
         sleep = fd[i].slp;
         run_period(0, '0, r, g, b);
         chk("fade_red", r, prev_r);
         chk("fade_bri", brightness, fd[i].bri);
         chk("fade_dark", faded_out, fd[i].fd);
         prev_r = fd[i].r;
      end
      sleep = 1;
      run_period(0, '0, r, g, b);
      run_period(0, '0, r, g, b);
      chk("pre_off_bri", brightness, 191);
      for (int k = 0; k < 50; k++) step();
      chk("pre_off_red", pwm_r, 1);
      en = 0;
      step();
      chk("off_pwm", {pwm_r, pwm_g, pwm_b}, 0);
      for (int k = 0; k < 10; k++) step();
      chk("off_hold_pwm", {pwm_r, pwm_g, pwm_b}, 0);
      chk("off_hold_bri", brightness, 191);
      en = 1;
      step();
      chk("reen_ps", period_start, 1);
      chk("reen_bri", brightness, 255);
      for (int k = 0; k < 4; k++) run_period(0, '0, r, g, b);
      chk("pre_rst_bri", brightness, 63);
      for (int k = 0; k < 20; k++) step();
      rst = 1;
      step();
      chk("mrst_bri", brightness, 255);
      chk("mrst_outs", {pwm_r, pwm_g, pwm_b, period_start, faded_out}, 0);
      rst = 0; sleep = 0;
      step();
      chk("resume_ps", period_start, 1);
      run_period(0, '0, r, g, b);
      chk("resume_red", r, 255);
      chk("resume_bri", brightness, 255);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
